lcd_hd44780_responder: RTL and testbench

// Behavioural HD44780-compatible LCD controller: the panel end of the 8-bit parallel LCD bus our driver writes.

---
 rtl/lcd_hd44780_responder.sv | 257 +++++++++++++++++++++++++
 tb/tb_lcd_hd44780_responder.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_hd44780_responder.sv
// HD44780-compatible panel model: samples the 8-bit LCD bus, decodes instructions and data
// accesses, and maintains DDRAM, the address counter, mode flags and busy timing.
module lcd_hd44780_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int BUSY_SHORT  = 2000,
  parameter int BUSY_LONG   = 82000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       lcd_en,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data_in,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  input  logic [6:0] scan_addr,
  output logic [7:0] scan_data,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       two_line,
  output logic       inc_mode,
  output logic [6:0] ac,
  output logic       busy,
  output logic       cmd_strobe,
  output logic       violation
);

  localparam int CW = $clog2(BUSY_LONG + 1);
  localparam logic [CW-1:0] LOAD_SHORT = CW'(BUSY_SHORT - 1);
  localparam logic [CW-1:0] LOAD_LONG  = CW'(BUSY_LONG - 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  logic [SYNC_STAGES-1:0]      en_pipe_q, en_pipe_d;
  logic [SYNC_STAGES-1:0]      rs_pipe_q, rs_pipe_d;
  logic [SYNC_STAGES-1:0]      rw_pipe_q, rw_pipe_d;
  logic [SYNC_STAGES-1:0][7:0] data_pipe_q, data_pipe_d;
  logic                        en_prev_q, en_prev_d;

  logic [6:0]    ac_q, ac_d;
  logic          disp_on_q, disp_on_d;
  logic          cursor_on_q, cursor_on_d;
  logic          blink_on_q, blink_on_d;
  logic          two_line_q, two_line_d;
  logic          inc_mode_q, inc_mode_d;
  logic [CW-1:0] busy_cnt_q, busy_cnt_d;
  logic          strobe_q, strobe_d;
  logic          viol_q, viol_d;
  logic [7:0]    scan_data_q, scan_data_d;

  state_e        state_q, state_d;
  logic [6:0]    clr_idx_q, clr_idx_d;
  logic          clr_wr;
  logic          clear_go;

  logic [7:0]    ddram_q [128];
  logic          mem_we;
  logic [6:0]    mem_waddr;
  logic [7:0]    mem_wdata;

  logic          en_s, rs_s, rw_s, e_fall, busy_w;
  logic [7:0]    data_s;

  assign en_s   = en_pipe_q[SYNC_STAGES-1];
  assign rs_s   = rs_pipe_q[SYNC_STAGES-1];
  assign rw_s   = rw_pipe_q[SYNC_STAGES-1];
  assign data_s = data_pipe_q[SYNC_STAGES-1];
  assign e_fall = en_prev_q & ~en_s;
  assign busy_w = (busy_cnt_q != '0) || (state_q == ST_CLEAR);

  // Next address-counter value, folding the visible line windows into a ring.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up, input logic two);
    logic [6:0] r;
    r = up ? a + 7'd1 : a - 7'd1;
    if (two) begin
      if (up && a == 7'h27)       r = 7'h40;
      else if (up && a == 7'h67)  r = 7'h00;
      else if (!up && a == 7'h40) r = 7'h27;
      else if (!up && a == 7'h00) r = 7'h67;
    end else begin
      if (up && a == 7'h4F)       r = 7'h00;
      else if (!up && a == 7'h00) r = 7'h4F;
    end
    return r;
  endfunction

  always_comb begin
    en_pipe_d   = {en_pipe_q[SYNC_STAGES-2:0], lcd_en};
    rs_pipe_d   = {rs_pipe_q[SYNC_STAGES-2:0], lcd_rs};
    rw_pipe_d   = {rw_pipe_q[SYNC_STAGES-2:0], lcd_rw};
    data_pipe_d = {data_pipe_q[SYNC_STAGES-2:0], lcd_data_in};
    en_prev_d   = en_s;
  end

  // NOTE: every signal gets a default before any branch, so no path leaves it unassigned (no latch).
  always_comb begin
    ac_d        = ac_q;
    disp_on_d   = disp_on_q;
    cursor_on_d = cursor_on_q;
    blink_on_d  = blink_on_q;
    two_line_d  = two_line_q;
    inc_mode_d  = inc_mode_q;
    busy_cnt_d  = (busy_cnt_q != '0) ? busy_cnt_q - CW'(1) : busy_cnt_q;
    strobe_d    = 1'b0;
    viol_d      = 1'b0;
    clear_go    = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = ac_q;
    mem_wdata   = data_s;

    if (e_fall) begin
      if (!rs_s && rw_s) begin
        strobe_d = 1'b1;
      end else if (busy_w) begin
        viol_d = 1'b1;
      end else if (rs_s) begin
        strobe_d   = 1'b1;
        mem_we     = ~rw_s;
        ac_d       = ac_step(ac_q, inc_mode_q, two_line_q);
        busy_cnt_d = LOAD_SHORT;
      end else begin
        strobe_d = 1'b1;
        casez (data_s)
          8'b1???????: begin
            ac_d       = data_s[6:0];
            busy_cnt_d = LOAD_SHORT;
          end
          8'b01??????: viol_d = 1'b1;
          8'b001?????: begin
            two_line_d = data_s[3];
            viol_d     = ~data_s[4];
            busy_cnt_d = LOAD_SHORT;
          end
          8'b0001????: begin
            if (data_s[3]) viol_d = 1'b1;
            else           ac_d   = ac_step(ac_q, data_s[2], two_line_q);
            busy_cnt_d = LOAD_SHORT;
          end
          8'b00001???: begin
            disp_on_d   = data_s[2];
            cursor_on_d = data_s[1];
            blink_on_d  = data_s[0];
            busy_cnt_d  = LOAD_SHORT;
          end
          8'b000001??: begin
            inc_mode_d = data_s[1];
            viol_d     = data_s[0];
            busy_cnt_d = LOAD_SHORT;
          end
          8'b0000001?: begin
            ac_d       = '0;
            busy_cnt_d = LOAD_LONG;
          end
          8'b00000001: begin
            ac_d       = '0;
            inc_mode_d = 1'b1;
            clear_go   = 1'b1;
            busy_cnt_d = LOAD_LONG;
          end
          default: viol_d = 1'b1;
        endcase
      end
    end

    if (clr_wr) begin
      mem_we    = 1'b1;
      mem_waddr = clr_idx_q;
      mem_wdata = 8'h20;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      en_pipe_q   <= '0;
      rs_pipe_q   <= '0;
      rw_pipe_q   <= '0;
      data_pipe_q <= '0;
      en_prev_q   <= 1'b0;
      ac_q        <= '0;
      disp_on_q   <= 1'b0;
      cursor_on_q <= 1'b0;
      blink_on_q  <= 1'b0;
      two_line_q  <= 1'b0;
      inc_mode_q  <= 1'b1;
      busy_cnt_q  <= '0;
      strobe_q    <= 1'b0;
      viol_q      <= 1'b0;
      scan_data_q <= '0;
    end else begin
      en_pipe_q   <= en_pipe_d;
      rs_pipe_q   <= rs_pipe_d;
      rw_pipe_q   <= rw_pipe_d;
      data_pipe_q <= data_pipe_d;
      en_prev_q   <= en_prev_d;
      ac_q        <= ac_d;
      disp_on_q   <= disp_on_d;
      cursor_on_q <= cursor_on_d;
      blink_on_q  <= blink_on_d;
      two_line_q  <= two_line_d;
      inc_mode_q  <= inc_mode_d;
      busy_cnt_q  <= busy_cnt_d;
      strobe_q    <= strobe_d;
      viol_q      <= viol_d;
      scan_data_q <= scan_data_d;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (clear_go) state_d = ST_CLEAR;
      ST_CLEAR: if (clr_idx_q == 7'd127) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    clr_wr    = (state_q == ST_CLEAR);
    clr_idx_d = clr_wr ? clr_idx_q + 7'd1 : 7'd0;
  end

  // NOTE: DDRAM contents are never reset; reset only blocks the write so a clear stops mid-way.
  always_ff @(posedge CLOCK_50) begin
    if (mem_we && !reset) ddram_q[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    scan_data_d  = ddram_q[scan_addr];
    lcd_data_oe  = en_s & rw_s;
    lcd_data_out = '0;
    if (lcd_data_oe) lcd_data_out = rs_s ? ddram_q[ac_q] : {busy_w, ac_q};
  end

  assign scan_data  = scan_data_q;
  assign disp_on    = disp_on_q;
  assign cursor_on  = cursor_on_q;
  assign blink_on   = blink_on_q;
  assign two_line   = two_line_q;
  assign inc_mode   = inc_mode_q;
  assign ac         = ac_q;
  assign busy       = busy_w;
  assign cmd_strobe = strobe_q;
  assign violation  = viol_q;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Bench for lcd_hd44780_responder: drives the LCD bus like the host driver and compares the
// panel state against a behavioural model of the controller.
`timescale 1ns/1ps
module tb_lcd_hd44780_responder;
  localparam int SYNC_STAGES = 2;
  localparam int BUSY_SHORT  = 60;
  localparam int BUSY_LONG   = 300;
  localparam int EN_HIGH     = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       lcd_en = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
  logic [7:0] lcd_data_in = '0;
  logic [6:0] scan_addr = '0;
  logic [7:0] lcd_data_out, scan_data;
  logic       lcd_data_oe, disp_on, cursor_on, blink_on, two_line, inc_mode;
  logic [6:0] ac;
  logic       busy, cmd_strobe, violation;

  lcd_hd44780_responder #(
    .SYNC_STAGES(SYNC_STAGES), .BUSY_SHORT(BUSY_SHORT), .BUSY_LONG(BUSY_LONG)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_data_in(lcd_data_in), .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe),
    .scan_addr(scan_addr), .scan_data(scan_data), .disp_on(disp_on), .cursor_on(cursor_on),
    .blink_on(blink_on), .two_line(two_line), .inc_mode(inc_mode), .ac(ac), .busy(busy),
    .cmd_strobe(cmd_strobe), .violation(violation)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, viol_cnt = 0, strobe_cnt = 0;

  logic [7:0] ref_mem [128];
  logic [6:0] ref_ac;
  bit         ref_inc, ref_two, ref_disp, ref_cur, ref_blink;

  always @(negedge clk) begin
    if (violation === 1'b1)  viol_cnt++;
    if (cmd_strobe === 1'b1) strobe_cnt++;
  end

  // Address step: visible addresses form one ring per display mode; others step mod 128.
  function automatic logic [6:0] m_step(input logic [6:0] a, input bit up, input bit two);
    int ring[$];
    int k = -1;
    int n;
    for (int i = 0; i < 128; i++)
      if (two ? ((i < 40) || (i >= 64 && i < 104)) : (i < 80)) ring.push_back(i);
    foreach (ring[j]) if (ring[j] == int'(a)) k = j;
    if (k < 0) return up ? 7'((int'(a) + 1) % 128) : 7'((int'(a) + 127) % 128);
    n = ring.size();
    return 7'(ring[(k + (up ? 1 : n - 1)) % n]);
  endfunction

  task automatic m_apply(input bit rs, input bit rw, input logic [7:0] d);
    if (rs) begin
      if (!rw) ref_mem[ref_ac] = d;
      ref_ac = m_step(ref_ac, ref_inc, ref_two);
    end else if (!rw) begin
      if (d[7])      ref_ac = d[6:0];
      else if (d[6]) begin end
      else if (d[5]) ref_two = d[3];
      else if (d[4]) begin if (!d[3]) ref_ac = m_step(ref_ac, d[2], ref_two); end
      else if (d[3]) begin ref_disp = d[2]; ref_cur = d[1]; ref_blink = d[0]; end
      else if (d[2]) ref_inc = d[1];
      else if (d[1]) ref_ac = '0;
      else if (d[0]) begin
        ref_ac = '0; ref_inc = 1'b1;
        for (int i = 0; i < 128; i++) ref_mem[i] = 8'h20;
      end
    end
  endtask

  task automatic issue(input bit rs, input bit rw, input logic [7:0] d);
    @(negedge clk); lcd_rs = rs; lcd_rw = rw; lcd_data_in = d;
    @(negedge clk); lcd_en = 1'b1;
    repeat (EN_HIGH) @(negedge clk);
    lcd_en = 1'b0;
  endtask

  task automatic bus_access(input bit rs, input bit rw, input logic [7:0] d);
    issue(rs, rw, d);
    repeat (5) @(negedge clk);
  endtask

  task automatic read_access(input bit rs, output logic oe, output logic [7:0] dout);
    @(negedge clk); lcd_rs = rs; lcd_rw = 1'b1; lcd_data_in = '0;
    @(negedge clk); lcd_en = 1'b1;
    repeat (EN_HIGH) @(negedge clk);
    oe = lcd_data_oe; dout = lcd_data_out;
    lcd_en = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic wait_idle();
    int c = 0;
    while (busy !== 1'b0 && c < 4 * BUSY_LONG) begin @(negedge clk); c++; end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL wait_idle: busy=%b after %0d cycles, need 0", busy, c); end
    @(negedge clk);
  endtask

  task automatic wr(input bit rs, input logic [7:0] d);
    bus_access(rs, 1'b0, d);
    m_apply(rs, 1'b0, d);
    wait_idle();
  endtask

  // Issues an access, waits for its strobe, returns how many cycles busy then stays high.
  task automatic timed_access(input logic [7:0] d, output int cycles);
    int w = 0;
    issue(1'b0, 1'b0, d);
    while (cmd_strobe !== 1'b1 && w < 10) begin @(negedge clk); w++; end
    n_tests++;
    if (cmd_strobe !== 1'b1) begin n_fail++; $display("FAIL strobe_wait: cmd_strobe=%b, need 1", cmd_strobe); end
    cycles = 0;
    while (busy === 1'b1 && cycles < 4 * BUSY_LONG) begin cycles++; @(negedge clk); end
    m_apply(1'b0, 1'b0, d);
    @(negedge clk);
  endtask

  task automatic check_state(input string tag);
    n_tests++;
    if (ac !== ref_ac) begin n_fail++; $display("FAIL %s ac: got %h need %h", tag, ac, ref_ac); end
    n_tests++;
    if ({disp_on, cursor_on, blink_on, two_line, inc_mode} !== {ref_disp, ref_cur, ref_blink, ref_two, ref_inc}) begin
      n_fail++;
      $display("FAIL %s flags: got %b need %b", tag, {disp_on, cursor_on, blink_on, two_line, inc_mode},
               {ref_disp, ref_cur, ref_blink, ref_two, ref_inc});
    end
  endtask

  task automatic check_scan(input logic [6:0] a, input string tag);
    scan_addr = a;
    @(negedge clk);
    n_tests++;
    if (scan_data !== ref_mem[a]) begin n_fail++; $display("FAIL %s scan[%h]: got %h need %h", tag, a, scan_data, ref_mem[a]); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({ac, busy, inc_mode, disp_on, cursor_on, blink_on, two_line} !== {7'd0, 1'b0, 1'b1, 4'b0}) begin
      n_fail++; $display("FAIL reset_state: got ac=%h busy=%b inc=%b flags=%b", ac, busy, inc_mode,
                         {disp_on, cursor_on, blink_on, two_line});
    end
    n_tests++;
    if ({lcd_data_oe, lcd_data_out, cmd_strobe, violation, scan_data} !== 19'd0) begin
      n_fail++; $display("FAIL reset_outputs: got oe=%b out=%h strobe=%b viol=%b scan=%h", lcd_data_oe,
                         lcd_data_out, cmd_strobe, violation, scan_data);
    end
    reset = 1'b0;
    ref_ac = '0; ref_inc = 1'b1; ref_two = 1'b0; ref_disp = 1'b0; ref_cur = 1'b0; ref_blink = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_init();
    int v0 = viol_cnt, s0 = strobe_cnt, c;
    timed_access(8'h38, c);
    n_tests++;
    if (c < BUSY_SHORT - 2 || c > BUSY_SHORT + 1) begin n_fail++; $display("FAIL busy_short_len: got %0d need ~%0d", c, BUSY_SHORT); end
    wr(1'b0, 8'h0C);
    wr(1'b0, 8'h06);
    check_state("init");
    n_tests++;
    if (viol_cnt - v0 !== 0 || strobe_cnt - s0 !== 3) begin
      n_fail++; $display("FAIL init_pulses: got viol=%0d strobe=%0d need 0 and 3", viol_cnt - v0, strobe_cnt - s0);
    end
  endtask

  task automatic test_clear();
    int c, bad = 0, first_bad = -1;
    wr(1'b0, 8'h85);
    wr(1'b0, 8'h04);
    timed_access(8'h01, c);
    n_tests++;
    if (c < BUSY_LONG - 2 || c > BUSY_LONG + 1) begin n_fail++; $display("FAIL busy_long_len: got %0d need ~%0d", c, BUSY_LONG); end
    check_state("clear");
    for (int a = 0; a < 128; a++) begin
      scan_addr = 7'(a);
      @(negedge clk);
      if (scan_data !== 8'h20) begin bad++; if (first_bad < 0) first_bad = a; end
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL clear_fill: %0d bytes not 20, first at %0d", bad, first_bad); end
  endtask

  task automatic test_data_write();
    wr(1'b0, 8'h80);
    wr(1'b1, 8'h48);
    wr(1'b1, 8'h69);
    check_state("data_write");
    check_scan(7'h00, "data_write");
    check_scan(7'h01, "data_write");
  endtask

  task automatic test_wrap();
    wr(1'b0, 8'hA7);
    wr(1'b1, 8'h41);
    check_state("wrap_up");
    check_scan(7'h27, "wrap_up");
    wr(1'b0, 8'h04);
    wr(1'b0, 8'h80);
    wr(1'b1, 8'h33);
    check_state("wrap_down");
    check_scan(7'h00, "wrap_down");
  endtask

  task automatic test_busy_violation();
    int v0;
    logic oe;
    logic [7:0] dout;
    wr(1'b0, 8'h06);
    wr(1'b0, 8'h90);
    v0 = viol_cnt;
    bus_access(1'b1, 1'b0, 8'hC3);
    m_apply(1'b1, 1'b0, 8'hC3);
    bus_access(1'b1, 1'b0, 8'h41);
    read_access(1'b0, oe, dout);
    n_tests++;
    if (oe !== 1'b1 || dout !== {1'b1, ref_ac}) begin
      n_fail++; $display("FAIL busy_read: got oe=%b out=%h need 1 and %h", oe, dout, {1'b1, ref_ac});
    end
    n_tests++;
    if (viol_cnt - v0 !== 1) begin n_fail++; $display("FAIL busy_write_viol: got %0d pulses need 1", viol_cnt - v0); end
    wait_idle();
    check_state("busy_violation");
    check_scan(7'h10, "busy_violation");
    check_scan(7'h11, "busy_violation");
  endtask

  task automatic test_read_data();
    logic oe;
    logic [7:0] dout;
    wr(1'b0, 8'h80);
    wr(1'b1, 8'h5A);
    wr(1'b0, 8'h80);
    read_access(1'b1, oe, dout);
    n_tests++;
    if (oe !== 1'b1 || dout !== 8'h5A) begin n_fail++; $display("FAIL data_read: got oe=%b out=%h need 1 and 5a", oe, dout); end
    m_apply(1'b1, 1'b1, 8'h00);
    wait_idle();
    check_state("data_read");
  endtask

  task automatic test_violations();
    int v0 = viol_cnt;
    bus_access(1'b0, 1'b0, 8'h40);
    n_tests++;
    if (busy !== 1'b0 || viol_cnt - v0 !== 1) begin
      n_fail++; $display("FAIL cgram: got busy=%b viol=%0d need 0 and 1", busy, viol_cnt - v0);
    end
    bus_access(1'b0, 1'b0, 8'h00);
    n_tests++;
    if (busy !== 1'b0 || viol_cnt - v0 !== 2) begin
      n_fail++; $display("FAIL nop: got busy=%b viol=%0d need 0 and 2", busy, viol_cnt - v0);
    end
    wr(1'b0, 8'h20);
    wr(1'b0, 8'h18);
    wr(1'b0, 8'h07);
    check_state("violations");
    n_tests++;
    if (viol_cnt - v0 !== 5) begin n_fail++; $display("FAIL viol_count: got %0d need 5", viol_cnt - v0); end
    wr(1'b0, 8'h38);
  endtask

  task automatic test_random();
    logic oe;
    logic [7:0] dout, d;
    for (int it = 0; it < 60; it++) begin
      d = 8'($urandom);
      case ($urandom_range(0, 6))
        0: wr(1'b0, 8'h80 | d);
        1: wr(1'b1, d);
        2: wr(1'b0, 8'h04 | (d & 8'h02));
        3: wr(1'b0, 8'h10 | (d & 8'h04));
        4: wr(1'b0, 8'h30 | (d & 8'h08));
        5: wr(1'b0, 8'h08 | (d & 8'h07));
        default: begin
          read_access(1'b1, oe, dout);
          n_tests++;
          if (oe !== 1'b1 || dout !== ref_mem[ref_ac]) begin
            n_fail++; $display("FAIL rand_read: got oe=%b out=%h need 1 and %h", oe, dout, ref_mem[ref_ac]);
          end
          m_apply(1'b1, 1'b1, 8'h00);
          wait_idle();
        end
      endcase
      check_state("random");
      check_scan(7'($urandom), "random");
    end
  endtask

  task automatic test_back_to_back();
    int v0, c = 0;
    wr(1'b0, 8'h06);
    wr(1'b0, 8'h85);
    v0 = viol_cnt;
    bus_access(1'b1, 1'b0, 8'h11);
    m_apply(1'b1, 1'b0, 8'h11);
    while (busy !== 1'b0 && c < 4 * BUSY_LONG) begin @(negedge clk); c++; end
    bus_access(1'b1, 1'b0, 8'h22);
    m_apply(1'b1, 1'b0, 8'h22);
    wait_idle();
    n_tests++;
    if (viol_cnt - v0 !== 0) begin n_fail++; $display("FAIL back_to_back_viol: got %0d need 0", viol_cnt - v0); end
    check_state("back_to_back");
    check_scan(7'h05, "back_to_back");
    check_scan(7'h06, "back_to_back");
  endtask

  task automatic test_reset_mid_clear();
    int w = 0, bad_lo = 0, bad_hi = 0;
    for (int a = 0; a < 128; a++) begin
      wr(1'b0, 8'h80 | 8'(a));
      wr(1'b1, 8'($urandom) | 8'h80);
    end
    issue(1'b0, 1'b0, 8'h01);
    while (cmd_strobe !== 1'b1 && w < 10) begin @(negedge clk); w++; end
    repeat (50) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || ac !== 7'd0) begin n_fail++; $display("FAIL abort_state: got busy=%b ac=%h need 0 0", busy, ac); end
    for (int a = 0; a < 128; a++) begin
      scan_addr = 7'(a);
      @(negedge clk);
      if (a < 45 && scan_data !== 8'h20) bad_lo++;
      if (a >= 56 && scan_data !== ref_mem[a]) bad_hi++;
    end
    n_tests++;
    if (bad_lo != 0) begin n_fail++; $display("FAIL abort_cleared_part: %0d low bytes not 20", bad_lo); end
    n_tests++;
    if (bad_hi != 0) begin n_fail++; $display("FAIL abort_untouched_part: %0d high bytes changed", bad_hi); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_clear();
    test_data_write();
    test_wrap();
    test_busy_violation();
    test_read_data();
    test_violations();
    test_random();
    test_back_to_back();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
